// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// request handshake, buffers one word in a skid register when decode
// stalls, and stops fetching once a HALT word has been captured.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [4:0]  HALT_OPC  = 5'b00000,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_done,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] currPC,
   output logic [15:0] INSTR,
   output logic [15:0] pc_plus2,
   output logic        valid,
   output logic        halted
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HALTED} state_t;

   state_t      r_state;
   logic [15:0] r_pc;          // next fetch address
   logic [15:0] r_drain_addr;  // address of the read being thrown away
   logic [15:0] r_instr;
   logic [15:0] r_curr_pc;
   logic        r_valid;
   logic [15:0] r_skid_word;
   logic [15:0] r_skid_pc;
   logic        r_skid_valid;
   logic        r_req;
   logic        r_halted;

   logic        w_slot_free;
   logic        w_consume;
   logic        w_is_halt;

   assign w_slot_free = !r_valid || !stall;
   assign w_consume   = r_valid && !stall;
   assign w_is_halt   = (imem_data[15:11] == HALT_OPC);

   // While draining, the address must stay on the abandoned read even
   // though the PC already points at the redirect target.
   assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
   assign imem_req  = r_req;
   assign halted    = r_halted;
   assign currPC    = r_curr_pc;
   assign INSTR     = r_instr;
   assign valid     = r_valid;
   assign pc_plus2  = r_curr_pc + 16'd2;

   // Fetch FSM plus output/skid registers; redirect overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
         r_instr      <= NOP_INSTR;
         r_curr_pc    <= 16'h0000;
         r_valid      <= 1'b0;
         r_skid_word  <= NOP_INSTR;
         r_skid_pc    <= 16'h0000;
         r_skid_valid <= 1'b0;
         r_req        <= 1'b0;
         r_halted     <= 1'b0;
      end else if (redirect) begin
         r_pc         <= redirect_pc;
         r_valid      <= 1'b0;
         r_skid_valid <= 1'b0;
         r_halted     <= 1'b0;
         case (r_state)
            S_WAIT: begin
               if (imem_done) begin
                  // The returning word belongs to the old path; drop it.
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end else begin
                  // Keep the handshake alive until the stale read finishes.
                  r_state      <= S_DRAIN;
                  r_req        <= 1'b1;
                  r_drain_addr <= r_pc;
               end
            end
            S_DRAIN: begin
               r_state <= S_DRAIN;
               r_req   <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end else begin
         // A consumed slot empties unless something below refills it.
         if (w_consume) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_slot_free) begin
                  if (r_skid_valid) begin
                     r_instr      <= r_skid_word;
                     r_curr_pc    <= r_skid_pc;
                     r_valid      <= 1'b1;
                     r_skid_valid <= 1'b0;
                  end else begin
                     r_state <= S_WAIT;
                     r_req   <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (imem_done) begin
                  r_pc <= r_pc + 16'd2;
                  if (w_slot_free) begin
                     r_instr   <= imem_data;
                     r_curr_pc <= r_pc;
                     r_valid   <= 1'b1;
                  end else begin
                     r_skid_word  <= imem_data;
                     r_skid_pc    <= r_pc;
                     r_skid_valid <= 1'b1;
                  end
                  if (w_is_halt) begin
                     r_state  <= S_HALTED;
                     r_req    <= 1'b0;
                     r_halted <= 1'b1;
                  end else if (!w_slot_free) begin
                     // Skid is occupied: pause requests until it empties.
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (imem_done) begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end
            end
            S_HALTED: begin
               // A HALT parked in skid still has to reach decode.
               if (w_slot_free && r_skid_valid) begin
                  r_instr      <= r_skid_word;
                  r_curr_pc    <= r_skid_pc;
                  r_valid      <= 1'b1;
                  r_skid_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed startup/stall/redirect/halt/reset cases
// followed by randomized stall, redirect and memory latency, checked
// against an in-order instruction-stream model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_done = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [15:0] currPC;
   logic [15:0] INSTR;
   logic [15:0] pc_plus2;
   logic        valid;
   logic        halted;

   // Second instance exercising PC wrap from RESET_PC = FFFE.
   logic        imem_req2;
   logic [15:0] imem_addr2;
   logic        imem_done2;
   logic [15:0] imem_data2;
   logic [15:0] currPC2;
   logic [15:0] INSTR2;
   logic [15:0] pc_plus2_2;
   logic        valid2;
   logic        halted2;

   assign imem_done2 = imem_req2;
   assign imem_data2 = {5'b10101, imem_addr2[10:0]};

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_done(imem_done), .imem_data(imem_data),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .currPC(currPC), .INSTR(INSTR), .pc_plus2(pc_plus2),
      .valid(valid), .halted(halted)
   );

   fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_done(imem_done2), .imem_data(imem_data2),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
      .currPC(currPC2), .INSTR(INSTR2), .pc_plus2(pc_plus2_2),
      .valid(valid2), .halted(halted2)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory image and responder state
   bit [15:0]   mem [0:65535];
   int          mem_lat = 0;        // negative means random 0..3 extra cycles
   bit          busy = 1'b0;
   int          rem = 0;
   logic [15:0] cur_addr = 16'h0000;

   // Stream model: next PC decode should see, and whether HALT was consumed
   logic [15:0] exp_pc = 16'h0000;
   bit          exp_halted = 1'b0;
   int          n_deliv = 0;

   // One clock cycle: memory response, input drive, stream check.
   task automatic cyc(input logic st, input logic rd, input logic [15:0] rpc);
      logic [15:0] w;
      @(negedge clk);
      if (imem_done) busy = 1'b0;
      imem_done = 1'b0;
      imem_data = 16'($urandom);
      if (imem_req) begin
         if (!busy) begin
            busy = 1'b1;
            cur_addr = imem_addr;
            rem = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
         end else begin
            check("addr_hold", imem_addr, cur_addr);
         end
         if (rem == 0) begin
            imem_done = 1'b1;
            imem_data = mem[cur_addr];
         end else begin
            rem--;
         end
      end else begin
         busy = 1'b0;
      end

      if (exp_halted) begin
         check("halt_valid", valid, 1'b0);
         check("halt_req", imem_req, 1'b0);
         check("halt_flag", halted, 1'b1);
      end

      stall = st;
      redirect = rd;
      redirect_pc = rpc;

      if (valid && !st && !rd) begin
         n_deliv++;
         $display("deliver pc=%h instr=%h", currPC, INSTR);
         w = mem[exp_pc];
         check("deliv_pc", currPC, exp_pc);
         check("deliv_instr", INSTR, w);
         check("deliv_pc2", pc_plus2, exp_pc + 16'd2);
         if (w[15:11] == 5'b00000) begin
            check("halt_at_deliv", halted, 1'b1);
            exp_halted = 1'b1;
         end
         exp_pc = exp_pc + 16'd2;
      end
      if (rd) begin
         exp_pc = rpc;
         exp_halted = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      imem_done = 1'b0;
      busy = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      exp_pc = 16'h0000;
      exp_halted = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_vals();
      check("rst_req", imem_req, 1'b0);
      check("rst_addr", imem_addr, 16'h0000);
      check("rst_currpc", currPC, 16'h0000);
      check("rst_instr", INSTR, 16'h0800);
      check("rst_pc2", pc_plus2, 16'h0002);
      check("rst_valid", valid, 1'b0);
      check("rst_halted", halted, 1'b0);
   endtask

   initial begin
      logic        st;
      logic        rd;
      logic [15:0] rpc;

      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1111;
      mem[2] = 16'h2222;
      mem[4] = 16'h3333;
      mem[6] = 16'h0000;

      // Reset values
      #1 rst_n = 1'b0;
      #2;
      check_reset_vals();
      check("rst2_addr", imem_addr2, 16'hFFFE);
      check("rst2_pc2", pc_plus2_2, 16'h0002);

      // Straight-line fetch, stall in cycles 3..5, HALT at 0006
      mem_lat = 0;
      exp_pc = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 1
      check("c1_req", imem_req, 1'b1);
      check("c1_addr", imem_addr, 16'h0000);
      check("c1_valid", valid, 1'b0);
      check("c1_addr2", imem_addr2, 16'hFFFE);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 2
      check("c2_addr", imem_addr, 16'h0002);
      check("c2_valid", valid, 1'b1);
      check("c2_currpc", currPC, 16'h0000);
      check("c2_pc2", pc_plus2, 16'h0002);
      check("c2_addr2", imem_addr2, 16'h0000);
      check("c2_currpc2", currPC2, 16'hFFFE);
      check("c2_pc2_wrap", pc_plus2_2, 16'h0000);
      check("c2_instr2", INSTR2, 16'hAFFE);
      check("c2_valid2", valid2, 1'b1);
      cyc(1'b1, 1'b0, 16'h0);                     // cycle 3
      check("c3_addr", imem_addr, 16'h0004);
      check("c3_currpc", currPC, 16'h0002);
      check("c3_pc2", pc_plus2, 16'h0004);
      check("c3_currpc2", currPC2, 16'h0000);
      check("c3_instr2", INSTR2, 16'hA800);
      check("c3_halted2", halted2, 1'b0);
      cyc(1'b1, 1'b0, 16'h0);                     // cycle 4
      check("c4_req", imem_req, 1'b0);
      check("c4_currpc", currPC, 16'h0002);
      cyc(1'b1, 1'b0, 16'h0);                     // cycle 5
      check("c5_req", imem_req, 1'b0);
      check("c5_instr", INSTR, 16'h2222);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 6
      check("c6_req", imem_req, 1'b0);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 7
      check("c7_currpc", currPC, 16'h0004);
      check("c7_instr", INSTR, 16'h3333);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 8
      check("c8_req", imem_req, 1'b1);
      check("c8_addr", imem_addr, 16'h0006);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 9
      check("c9_currpc", currPC, 16'h0006);
      check("c9_instr", INSTR, 16'h0000);
      check("c9_valid", valid, 1'b1);
      check("c9_halted", halted, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 16'h0);
         check("halt_quiet_req", imem_req, 1'b0);
      end
      cyc(1'b0, 1'b1, 16'h0010);                  // redirect out of HALTED
      cyc(1'b0, 1'b0, 16'h0);
      check("rdh_halted", halted, 1'b0);
      check("rdh_req", imem_req, 1'b0);
      cyc(1'b0, 1'b0, 16'h0);
      check("rdh_req2", imem_req, 1'b1);
      check("rdh_addr", imem_addr, 16'h0010);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0);

      // 3-cycle memory, redirect in the second WAIT cycle
      mem_lat = 2;
      do_reset();
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 1
      check("d1_addr", imem_addr, 16'h0000);
      cyc(1'b0, 1'b1, 16'h0040);                  // cycle 2
      check("d2_req", imem_req, 1'b1);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 3: draining
      check("d3_req", imem_req, 1'b1);
      check("d3_addr", imem_addr, 16'h0000);
      check("d3_valid", valid, 1'b0);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 4
      check("d4_req", imem_req, 1'b0);
      check("d4_valid", valid, 1'b0);
      cyc(1'b0, 1'b0, 16'h0);                     // cycle 5
      check("d5_req", imem_req, 1'b1);
      check("d5_addr", imem_addr, 16'h0040);
      check("d5_valid", valid, 1'b0);

      // Randomized stall / redirect / latency
      mem_lat = -1;
      n_deliv = 0;
      for (int i = 0; i < 3000; i++) begin
         st  = ($urandom_range(0, 9) < 3);
         rd  = ($urandom_range(0, 49) == 0);
         rpc = 16'($urandom) & 16'hFFFE;
         cyc(st, rd, rpc);
      end
      check("rand_progress", (n_deliv >= 100), 1'b1);

      // Asynchronous reset in the middle of a WAIT
      mem_lat = 3;
      do_reset();
      cyc(1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 16'h0);
      check("ar_req_before", imem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      imem_done = 1'b0;
      busy = 1'b0;
      exp_pc = 16'h0000;
      exp_halted = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 16'h0);
      check("ar_refetch_req", imem_req, 1'b1);
      check("ar_refetch_addr", imem_addr, 16'h0000);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 16'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-issue WISC processor. It sits directly upstream of decode and owns the PC register, the instruction-memory request handshake, a one-entry skid buffer and halt detection. It supplies `currPC` and `INSTR` to decode and to the trace bench. It accepts stall from the hazard unit and redirects (branch/jump targets) from later stages.

## Interface
- `RESET_PC`, 16'h0000: PC loaded at reset.
- `HALT_OPC`, 5'b00000: opcode (bits [15:11]) identifying HALT.
- `NOP_INSTR`, 16'h0800: value driven on `INSTR` when nothing valid has been delivered.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction-memory request, held until `imem_done`.
- `imem_addr`  out  16  fetch address, stable while `imem_req`=1.
- `imem_done`  in  1  read complete; valid only while `imem_req`=1, earliest in the first cycle of the request.
- `imem_data`  in  16  instruction word, valid with `imem_done`.
- `stall`  in  1  decode cannot accept; holds `INSTR`/`currPC`.
- `redirect`  in  1  one-cycle pulse requesting a PC change.
- `redirect_pc`  in  16  new PC, valid with `redirect`.
- `currPC`  out  16  PC of the word in `INSTR`.
- `INSTR`  out  16  instruction presented to decode.
- `pc_plus2`  out  16  `currPC`+2, combinational.
- `valid`  out  1  `INSTR` is a live instruction.
- `halted`  out  1  HALT has been fetched; fetching is stopped.

## Operation
- Internal state: `pc_reg` (next fetch address), output register (`INSTR`, `currPC`, `valid`), skid register (word, PC, `skid_valid`), FSM {IDLE, WAIT, DRAIN, HALTED}.
- Slot free: `!valid || !stall`. Decode consumes the output when `valid && !stall`. A consumed slot with nothing to refill it sets `valid`=0.
- IDLE:
  - `imem_req`=0.
  - If `skid_valid` and slot free, the skid word moves to the output register.
  - If `!skid_valid` and slot free, go to WAIT.
- WAIT:
  - `imem_req`=1, `imem_addr`=`pc_reg`.
  - On `imem_done`, `pc_reg`+=2 (mod 2^16). The word goes to the output register if the slot is free, otherwise to skid.
  - If the word's opcode equals `HALT_OPC`, go to HALTED.
  - Else if the word went to skid, go to IDLE.
  - Else stay in WAIT, which gives back-to-back requests.
- DRAIN:
  - `imem_req`=1, address held.
  - On `imem_done` the word is discarded; go to IDLE.
- HALTED:
  - `imem_req`=0 and `halted`=1.
  - The HALT word is still delivered to decode, through skid if needed.
- `redirect` has priority over everything, including `stall` and `imem_done`:
  - `pc_reg`<=`redirect_pc`; `valid`<=0; `skid_valid`<=0; `halted`<=0.
  - From WAIT without `imem_done` in the same cycle: go to DRAIN.
  - From WAIT with `imem_done` in the same cycle: word discarded; go to IDLE.
  - From DRAIN: stay in DRAIN.
  - From IDLE or HALTED: go to IDLE.
- `imem_done` in IDLE or HALTED is ignored.
- Arithmetic: all PC math is 16-bit and wraps, so FFFE+2=0000.

## Timing
- Reset (async, immediate):
  - state=IDLE, `pc_reg`=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `currPC`=0000, `INSTR`=`NOP_INSTR`, `pc_plus2`=0002.
  - `valid`=0, `halted`=0, `skid_valid`=0.
- Startup sequence after `rst_n` rises:
  - Cycle 0: IDLE.
  - Cycle 1: first request.
  - With single-cycle memory, `valid`=1 from cycle 2 and throughput is 1 word/cycle.
- Fetch latency from request to output is memory latency + 1 cycle.
- Skid word appears on the output one cycle after the slot frees. The next request is issued the following cycle.
- The first request after a redirect is at `redirect_pc`:
  - From IDLE: 1 cycle after the redirect.
  - From WAIT/DRAIN: 1 cycle after the discarded `imem_done`.
- `halted` rises the cycle after the HALT word is captured.
- Reset asserted mid-WAIT: `imem_req` drops immediately. An outstanding memory read is the memory's responsibility to abandon.

## Test plan
- Straight-line fetch, 1-cycle memory, words 0x1111/0x2222/0x3333 at 0000/0002/0004:
  - `imem_addr` is 0000, 0002, 0004 on cycles 1–3.
  - `valid`=1 from cycle 2 with `currPC` 0000, 0002, 0004 and `pc_plus2` 0002, 0004, 0006.
- Stall held cycles 3–5 during back-to-back fetch:
  - `INSTR`/`currPC` hold.
  - One word lands in skid and no request is issued while it is held.
  - Cycle after `stall` drops: skid word on output, next fetch at correct PC, no word lost or duplicated.
- 3-cycle memory, `redirect` to 0x0040 in the 2nd WAIT cycle:
  - DRAIN follows and the returned word is never valid.
  - Next `imem_addr`=0x0040.
- HALT (0x0000) at 0x0006:
  - Delivered with `currPC`=0006 and `halted`=1 the next cycle.
  - `imem_req`=0 for 20 cycles.
  - `redirect` to 0x0010 clears `halted` and fetches 0x0010.
- `RESET_PC`=16'hFFFE: fetches FFFE then 0000; `pc_plus2` of FFFE is 0000.
- `rst_n` dropped asynchronously mid-WAIT: all outputs reach reset values before the next clock edge, and refetch starts from `RESET_PC`.
